cp0_ctrl: RTL and testbench

Parametrised CP0 control block for the MIPS core: the successor to the fixed-function CP0 register file. It holds Count/Compare, Status, Cause, EPC, BadVAddr, PRId and Config, and adds a configurable Count prescaler and hardware-interrupt width. It also adds the following behaviour:
- a compare-match timer interrupt, cleared by writing Compare;
- nested-exception EPC protection;
- an interrupt-request output;
- an exception/ERET redirect target.

It sits beside the writeback stage; the exception-resolution logic drives it and the fetch redirect consumes it.

---
 rtl/cp0_pkg.sv | 44 ++++
 rtl/cp0_timer.sv | 75 +++++++
 rtl/cp0_ctrl.sv | 155 +++++++++++++++
 tb/tb_cp0_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_pkg
// Description : Shared constants for the CP0 control block. It holds the
//               register numbers, the ExcCode values, the Status reset value
//               and the software write masks for Status and Cause.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

    // CP0 register numbers (MTC0/MFC0 rd field)
    localparam logic [4:0] c_REG_BADVADDR = 5'd8;
    localparam logic [4:0] c_REG_COUNT    = 5'd9;
    localparam logic [4:0] c_REG_COMPARE  = 5'd11;
    localparam logic [4:0] c_REG_STATUS   = 5'd12;
    localparam logic [4:0] c_REG_CAUSE    = 5'd13;
    localparam logic [4:0] c_REG_EPC      = 5'd14;
    localparam logic [4:0] c_REG_PRID     = 5'd15;
    localparam logic [4:0] c_REG_CONFIG   = 5'd16;

    // ExcCode values
    localparam logic [4:0] c_EXC_INT  = 5'd0;
    localparam logic [4:0] c_EXC_ADEL = 5'd4;
    localparam logic [4:0] c_EXC_ADES = 5'd5;
    localparam logic [4:0] c_EXC_SYS  = 5'd8;
    localparam logic [4:0] c_EXC_BP   = 5'd9;
    localparam logic [4:0] c_EXC_RI   = 5'd10;
    localparam logic [4:0] c_EXC_OV   = 5'd12;
    localparam logic [4:0] c_EXC_TR   = 5'd13;

    // Status: BEV (bit 22) is hard-wired to 1
    localparam logic [31:0] c_STATUS_RESET = 32'h0040_0000;
    // Status software-writable bits: IM[15:8], EXL[1], IE[0]
    localparam logic [31:0] c_STATUS_WMASK = 32'h0000_FF03;
    // Cause software-writable bits: IP[9:8]
    localparam logic [31:0] c_CAUSE_WMASK  = 32'h0000_0300;

    // Address-error exceptions are the only ones that capture BadVAddr
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == c_EXC_ADEL) || (code == c_EXC_ADES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
// Module      : cp0_timer
// Description : Count/Compare timer with a programmable prescaler. Count
//               advances once every COUNT_DIV unstalled cycles; TI is set when
//               an increment lands on Compare and cleared by a Compare write.
// Ports       : clk, rst (sync, active-low), i_stall freezes everything,
//               i_count_we/i_count_wdata load Count, i_compare_we/
//               i_compare_wdata load Compare, o_count/o_compare/o_ti state.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_count_we,
    input  logic [31:0] i_count_wdata,
    input  logic        i_compare_we,
    input  logic [31:0] i_compare_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    localparam int c_PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(COUNT_DIV - 1);

    logic [c_PW-1:0] r_presc;
    logic [31:0]     r_count;
    logic [31:0]     r_compare;
    logic            r_ti;

    logic        w_wrap;
    logic [31:0] w_count_inc;

    assign w_wrap      = (r_presc == c_PRESC_MAX);
    assign w_count_inc = r_count + 32'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc   <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else if (!i_stall) begin
            if (i_count_we) begin
                // A software load restarts the prescaler phase
                r_count <= i_count_wdata;
                r_presc <= '0;
            end else if (w_wrap) begin
                r_presc <= '0;
                r_count <= w_count_inc;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            // Compare write wins over a match landing in the same cycle;
            // a Count load never evaluates a match.
            if (i_compare_we) begin
                r_compare <= i_compare_wdata;
                r_ti      <= 1'b0;
            end else if (!i_count_we && w_wrap && (w_count_inc == r_compare)) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule
`default_nettype wire

// File: rtl/cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cp0_ctrl
// Description : CP0 control block: Count/Compare timer, Status, Cause, EPC,
//               BadVAddr, PRId and Config, with interrupt request and
//               exception/ERET fetch redirect.
// Ports       : MTC0 write (we_i/waddr_i/wdata_i), MFC0 read (raddr_i ->
//               rdata_o), hw_int_i interrupt lines, exception commit
//               (exc_*_i), eret_i, stall_i; outputs int_req_o, redirect_pc_o
//               and the Status/Cause/EPC/Count registers.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_INT = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [4:0]            raddr_i,
    output logic [31:0]           rdata_o,
    input  logic [NUM_HW_INT-1:0] hw_int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_bd_i,
    input  logic [31:0]           exc_badvaddr_i,
    input  logic                  eret_i,
    output logic                  int_req_o,
    output logic [31:0]           redirect_pc_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           count_o
);

    logic [31:0]           r_status;   // holds BEV plus the writable bits
    logic [31:0]           r_cause_sw; // software-written IP[9:8]
    logic                  r_bd;
    logic [4:0]            r_exc_code;
    logic [NUM_HW_INT-1:0] r_ip_hw;
    logic [31:0]           r_epc;
    logic [31:0]           r_badvaddr;

    logic        w_wr_count, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc;
    logic [31:0] w_compare;
    logic        w_ti;
    logic [5:0]  w_hw_ext;
    logic [7:0]  w_ip;

    assign w_wr_count   = we_i && (waddr_i == c_REG_COUNT);
    assign w_wr_compare = we_i && (waddr_i == c_REG_COMPARE);
    assign w_wr_status  = we_i && (waddr_i == c_REG_STATUS);
    assign w_wr_cause   = we_i && (waddr_i == c_REG_CAUSE);
    assign w_wr_epc     = we_i && (waddr_i == c_REG_EPC);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk             (clk),
        .rst             (rst),
        .i_stall         (stall_i),
        .i_count_we      (w_wr_count),
        .i_count_wdata   (wdata_i),
        .i_compare_we    (w_wr_compare),
        .i_compare_wdata (wdata_i),
        .o_count         (count_o),
        .o_compare       (w_compare),
        .o_ti            (w_ti)
    );

    // Unused hardware IP positions read as zero
    always_comb begin
        w_hw_ext                   = '0;
        w_hw_ext[NUM_HW_INT-1:0]   = r_ip_hw;
    end

    // IP[7] shares the top line with the timer interrupt
    assign w_ip = {w_hw_ext[5] | w_ti, w_hw_ext[4:0], r_cause_sw[9:8]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_status   <= c_STATUS_RESET;
            r_cause_sw <= '0;
            r_bd       <= 1'b0;
            r_exc_code <= '0;
            r_ip_hw    <= '0;
            r_epc      <= '0;
            r_badvaddr <= '0;
        end else if (!stall_i) begin
            r_ip_hw <= hw_int_i;

            if (w_wr_status) begin
                r_status <= (wdata_i & c_STATUS_WMASK) | c_STATUS_RESET;
            end
            if (w_wr_cause) begin
                r_cause_sw <= wdata_i & c_CAUSE_WMASK;
            end
            if (w_wr_epc) begin
                r_epc <= wdata_i;
            end

            // Exception/ERET assignments come last so they override MTC0
            if (exc_valid_i) begin
                r_exc_code  <= exc_code_i;
                r_status[1] <= 1'b1;
                // Nested exception: keep the original return point
                if (!r_status[1]) begin
                    r_epc <= exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
                    r_bd  <= exc_bd_i;
                end
                if (is_addr_exc(exc_code_i)) begin
                    r_badvaddr <= exc_badvaddr_i;
                end
            end else if (eret_i) begin
                r_status[1] <= 1'b0;
            end
        end
    end

    assign status_o = r_status;
    assign cause_o  = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_exc_code, 2'b0};
    assign epc_o    = r_epc;

    assign int_req_o = r_status[0] & ~r_status[1] & (|(w_ip & r_status[15:8]));

    // An exception in the same cycle as ERET takes the exception vector
    assign redirect_pc_o = (eret_i && !exc_valid_i) ? r_epc : EXC_VECTOR;

    // BadVAddr is read-only from software
    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            c_REG_BADVADDR: rdata_o = r_badvaddr;
            c_REG_COUNT:    rdata_o = count_o;
            c_REG_COMPARE:  rdata_o = w_compare;
            c_REG_STATUS:   rdata_o = status_o;
            c_REG_CAUSE:    rdata_o = cause_o;
            c_REG_EPC:      rdata_o = r_epc;
            c_REG_PRID:     rdata_o = PRID_VAL;
            c_REG_CONFIG:   rdata_o = CONFIG_VAL;
            default:        rdata_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_ctrl
// Description : Self-checking bench for cp0_ctrl. A register-level model is
//               advanced at every clock edge from the applied inputs and all
//               outputs are compared one step after the edge; hand-computed
//               literals pin the key scenarios. A second instance with three
//               interrupt lines checks the narrow Cause layout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_ctrl;

    localparam int          COUNT_DIV = 2;
    localparam logic [31:0] VEC       = 32'hBFC0_0380;
    localparam logic [31:0] PRID      = 32'h004C_0102;
    localparam logic [31:0] CONFIG    = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        rst, stall, we, exc_valid, exc_bd, eret;
    logic [4:0]  waddr, raddr, exc_code;
    logic [31:0] wdata, exc_pc, exc_bva;
    logic [5:0]  hw;
    logic [2:0]  hw3;

    logic [31:0] rdata, redir, status, cause, epc, count;
    logic        int_req;
    logic [31:0] rdata3, redir3, status3, cause3, epc3, count3;
    logic        int_req3;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [4:0]  m_code;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_hw;
    logic [31:0] m_epc, m_bva, m_count, m_cmp;
    int          m_ticks;

    always #5 clk = ~clk;

    cp0_ctrl #(.NUM_HW_INT(6), .COUNT_DIV(COUNT_DIV)) u_dut (
        .clk(clk), .rst(rst), .stall_i(stall), .we_i(we), .waddr_i(waddr),
        .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rdata), .hw_int_i(hw),
        .exc_valid_i(exc_valid), .exc_code_i(exc_code), .exc_pc_i(exc_pc),
        .exc_bd_i(exc_bd), .exc_badvaddr_i(exc_bva), .eret_i(eret),
        .int_req_o(int_req), .redirect_pc_o(redir), .status_o(status),
        .cause_o(cause), .epc_o(epc), .count_o(count)
    );

    cp0_ctrl #(.NUM_HW_INT(3), .COUNT_DIV(COUNT_DIV)) u_dut3 (
        .clk(clk), .rst(rst), .stall_i(1'b0), .we_i(1'b0), .waddr_i(5'd0),
        .wdata_i(32'd0), .raddr_i(5'd13), .rdata_o(rdata3), .hw_int_i(hw3),
        .exc_valid_i(1'b0), .exc_code_i(5'd0), .exc_pc_i(32'd0),
        .exc_bd_i(1'b0), .exc_badvaddr_i(32'd0), .eret_i(1'b0),
        .int_req_o(int_req3), .redirect_pc_o(redir3), .status_o(status3),
        .cause_o(cause3), .epc_o(epc3), .count_o(count3)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [7:0] exp_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_ipsw};
    endfunction

    function automatic logic [31:0] exp_status();
        return 32'h0040_0000 | {16'b0, m_im, 6'b0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] exp_cause();
        return {m_bd, m_ti, 14'b0, exp_ip(), 1'b0, m_code, 2'b0};
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bva;
            5'd9:    return m_count;
            5'd11:   return m_cmp;
            5'd12:   return exp_status();
            5'd13:   return exp_cause();
            5'd14:   return m_epc;
            5'd15:   return PRID;
            5'd16:   return CONFIG;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs held across it
    task automatic model_edge();
        logic old_exl;
        old_exl = m_exl;
        if (!rst) begin
            m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_code = '0;
            m_ipsw = '0; m_hw = '0; m_epc = '0; m_bva = '0; m_count = '0;
            m_cmp = '0; m_ticks = 0;
        end else if (!stall) begin
            m_hw = hw;
            if (we && waddr == 5'd9) begin
                m_count = wdata;
                m_ticks = 0;
            end else begin
                m_ticks++;
                if (m_ticks % COUNT_DIV == 0) begin
                    m_count = m_count + 32'd1;
                    if (m_count == m_cmp) m_ti = 1'b1;
                end
            end
            if (we && waddr == 5'd11) begin m_cmp = wdata; m_ti = 1'b0; end
            if (we && waddr == 5'd12) begin
                m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0];
            end
            if (we && waddr == 5'd13) m_ipsw = wdata[9:8];
            if (we && waddr == 5'd14) m_epc = wdata;
            if (exc_valid) begin
                m_code = exc_code;
                m_exl  = 1'b1;
                if (!old_exl) begin
                    m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
                    m_bd  = exc_bd;
                end
                if (exc_code == 5'd4 || exc_code == 5'd5) m_bva = exc_bva;
            end else if (eret) begin
                m_exl = 1'b0;
            end
        end
    endtask

    // One clock: check the combinational redirect, cross the edge, check all
    task automatic step();
        #1;
        chk("redirect_comb", redir, (eret && !exc_valid) ? m_epc : VEC);
        @(posedge clk);
        model_edge();
        #1;
        chk("status", status, exp_status());
        chk("cause", cause, exp_cause());
        chk("epc", epc, m_epc);
        chk("count", count, m_count);
        chk("int_req", {31'b0, int_req},
            {31'b0, m_ie & ~m_exl & (|(exp_ip() & m_im))});
        chk("rdata", rdata, exp_read(raddr));
    endtask

    task automatic idle(input int n);
        logic [4:0] rl [0:8];
        rl = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
        for (int i = 0; i < n; i++) begin
            raddr = rl[i % 9];
            step();
        end
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 0; stall = 0; we = 0; waddr = 0; wdata = 0; raddr = 5'd9;
        hw = 0; hw3 = 0; exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0;
        exc_bva = 0; eret = 0;
        m_ticks = 0;
        step(); step();
        chk("rst_status", status, 32'h0040_0000);
        chk("rst_count", count, 32'd0);
        chk("rst_int_req", {31'b0, int_req}, 32'd0);
        chk("rst_redirect", redir, VEC);
        chk("rst_cause3", cause3, 32'd0);

        // Prescaler: 10 unstalled cycles -> Count 5
        rst = 1;
        idle(10);
        chk("count_10cyc", count, 32'd5);

        // 4 of 10 cycles stalled (with a blocked Status write) -> Count 3
        rst = 0; step(); rst = 1;
        for (int i = 0; i < 10; i++) begin
            stall = (i >= 2 && i < 6);
            we = stall; waddr = 5'd12; wdata = 32'hFFFF_FFFF;
            step();
        end
        stall = 0; we = 0;
        chk("count_stalled", count, 32'd3);
        chk("status_stall_blocked", status, 32'h0040_0000);

        // Timer match
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd18);
        raddr = 5'd13;
        step(); step(); step();
        chk("ti_not_yet", {31'b0, cause[30]}, 32'd0);
        step();
        chk("ti_set", {31'b0, cause[30]}, 32'd1);
        chk("ip7_set", {31'b0, cause[15]}, 32'd1);
        chk("int_req_timer", {31'b0, int_req}, 32'd1);
        mtc0(5'd11, 32'd100);
        chk("ti_cleared", {31'b0, cause[30]}, 32'd0);
        chk("int_req_cleared", {31'b0, int_req}, 32'd0);

        // Count load equal to Compare does not match
        mtc0(5'd11, 32'd50);
        mtc0(5'd9, 32'd50);
        step();
        chk("load_no_match", {31'b0, cause[30]}, 32'd0);

        // Compare = 0 matches on the wrap
        mtc0(5'd11, 32'd0);
        mtc0(5'd9, 32'hFFFF_FFFF);
        step(); step();
        chk("wrap_count", count, 32'd0);
        chk("wrap_ti", {31'b0, cause[30]}, 32'd1);

        // Match and Compare write on the same edge -> TI stays 0
        mtc0(5'd9, 32'hFFFF_FFFF);
        step();
        mtc0(5'd11, 32'd0);
        chk("same_cycle_count", count, 32'd0);
        chk("same_cycle_ti", {31'b0, cause[30]}, 32'd0);

        // Address-error exception in a delay slot
        exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h8000_1004; exc_bd = 1;
        exc_bva = 32'h13;
        raddr = 5'd8;
        step();
        exc_valid = 0;
        chk("exc_epc", epc, 32'h8000_1000);
        chk("exc_cause", cause, 32'h8000_0010);
        chk("exc_badvaddr", rdata, 32'h0000_0013);
        chk("exc_exl", {31'b0, status[1]}, 32'd1);
        chk("exc_redirect", redir, VEC);

        // Nested syscall: EPC, BD and BadVAddr held
        exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h8000_2000; exc_bd = 0;
        exc_bva = 32'h55;
        step();
        exc_valid = 0;
        chk("nested_cause", cause, 32'h8000_0020);
        chk("nested_epc", epc, 32'h8000_1000);
        chk("nested_badvaddr", rdata, 32'h0000_0013);

        // ERET
        eret = 1;
        #1 chk("eret_redirect", redir, 32'h8000_1000);
        step();
        eret = 0;
        chk("eret_exl", {31'b0, status[1]}, 32'd0);

        // Status write masking, and exception beating MTC0 on EXL
        mtc0(5'd12, 32'hFFFF_FFFF);
        chk("status_mask", status, 32'h0040_FF03);
        mtc0(5'd12, 32'd0);
        exc_valid = 1; exc_code = 5'd12; exc_pc = 32'h8000_3000; exc_bd = 0;
        mtc0(5'd12, 32'd0);
        exc_valid = 0;
        chk("exc_beats_mtc0", status, 32'h0040_0002);
        chk("exc_epc2", epc, 32'h8000_3000);
        eret = 1;
        mtc0(5'd12, 32'h0000_0003);
        eret = 0;
        chk("eret_beats_mtc0", status, 32'h0040_0001);

        // Hardware interrupt: one-cycle sampling latency
        mtc0(5'd12, 32'h0000_0401);
        hw = 6'b000001;
        #1 chk("hw_int_before", {31'b0, int_req}, 32'd0);
        step();
        chk("hw_int_after", {31'b0, int_req}, 32'd1);
        mtc0(5'd13, 32'hFFFF_FFFF);
        hw = 6'b100000;
        idle(3);
        hw = 6'b0;
        step();

        // Narrow instance: hw_int_i[2] lands in Cause[12]
        hw3 = 3'b100;
        step();
        chk("cause3_hw2", cause3, 32'h0000_1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
